// File: rtl/mult_seq.sv
// Sequential signed WIDTHxWIDTH multiplier (MIPS MULT), shift-add on magnitudes with final sign fix.
// Latency: start sampled at edge N, done/hi/lo valid in the cycle after edge N+WIDTH+1.
// Backpressure: none; start is only sampled in IDLE, requests while busy are dropped.
// Optional MULT_MULTU_EN: adds is_unsigned input selecting MULTU (unsigned) semantics.
module mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef MULT_MULTU_EN
  input  logic             is_unsigned,
`endif
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FINISH
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Operand conditioning: magnitudes of the inputs and the product sign.
  // The most negative value negates to itself, which is exactly its
  // unsigned magnitude, so no extra bit is needed.
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic                 sign_prod;

  // Datapath temporaries for one shift-add step and the final sign fix.
  logic [WIDTH:0]       sum;
  logic [2*WIDTH:0]     shifted;
  logic [2*WIDTH-1:0]   prod;

  // Select operand magnitudes and result sign for the incoming request.
  always_comb begin
    mag_a     = A[WIDTH-1] ? (~A + 1'b1) : A;
    mag_b     = B[WIDTH-1] ? (~B + 1'b1) : B;
    sign_prod = A[WIDTH-1] ^ B[WIDTH-1];
`ifdef MULT_MULTU_EN
    if (is_unsigned) begin
      mag_a     = A;
      mag_b     = B;
      sign_prod = 1'b0;
    end
`endif
  end

  // Next-state logic: FSM transitions plus datapath updates.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    // Upper half plus (optionally) the multiplicand, carry kept in bit WIDTH.
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
               (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    shifted  = {sum, acc_q[WIDTH-1:0]};
    prod     = neg_q ? (~acc_q + 1'b1) : acc_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = mag_a;
          mplier_d = mag_b;
          neg_d    = sign_prod;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        acc_d    = shifted[2*WIDTH:1];
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        // Negating zero yields zero, so a zero product never turns into -0.
        hi_d    = prod[2*WIDTH-1:WIDTH];
        lo_d    = prod[WIDTH-1:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq: vector table of signed products plus
// hand-written sequences for start-while-busy and asynchronous reset.
module tb_mult_seq;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
`ifdef MULT_MULTU_EN
  logic         is_u;
`endif

  int total;
  int bad;
  logic [W-1:0] prev_hi;
  logic [W-1:0] prev_lo;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] h;
    logic [W-1:0] l;
  } vec_t;

  vec_t vt[10];

  mult_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
`ifdef MULT_MULTU_EN
    .is_unsigned (is_u),
`endif
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One full operation: start pulse, wait bounded for done, check result.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el,
                        input string nm);
    int lat;
    bit found;
    logic [W-1:0] got_hi, got_lo;
    logic got_busy;
    lat = 0;
    found = 0;
    got_hi = '0;
    got_lo = '0;
    got_busy = 1'b1;
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Operands must already be latched; scramble the inputs.
    A = $urandom;
    B = $urandom;
    chk({nm, " busy after start"}, 64'(busy), 64'd1);
    for (int k = 1; k <= 40 && !found; k++) begin
      @(negedge clk);
      if (k == 16) chk({nm, " hold during calc"}, {hi, lo}, {prev_hi, prev_lo});
      if (done) begin
        found = 1;
        lat = k;
        got_hi = hi;
        got_lo = lo;
        got_busy = busy;
      end
    end
    chk({nm, " latency"}, 64'(lat), 64'(LAT));
    chk({nm, " product"}, {got_hi, got_lo}, {eh, el});
    chk({nm, " busy at done"}, 64'(got_busy), 64'd0);
    @(negedge clk);
    chk({nm, " done one cycle"}, 64'(done), 64'd0);
    prev_hi = eh;
    prev_lo = el;
  endtask

  initial begin
    int dones;
    int first_done;
    logic [W-1:0] cap_hi, cap_lo;

    total = 0;
    bad = 0;
    prev_hi = '0;
    prev_lo = '0;
    reset = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
`ifdef MULT_MULTU_EN
    is_u = 1'b0;
`endif

    vt[0] = {32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vt[1] = {32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vt[2] = {32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    vt[3] = {32'd0,        32'hFFFFFFFB, 32'h00000000, 32'h00000000};
    vt[4] = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vt[5] = {32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vt[6] = {32'd12345,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFCFC7};
    vt[7] = {32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000};
    vt[8] = {32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vt[9] = {32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

    // Reset state.
    #2 reset = 1'b0;
    #10;
    chk("reset hi/lo", {hi, lo}, 64'd0);
    chk("reset busy/done", {62'd0, busy, done}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Table-driven products.
    for (int i = 0; i < 10; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].h, vt[i].l, $sformatf("vec%0d", i));
    end

    // Start while busy must be ignored; operand inputs changing mid-calc too.
    @(negedge clk);
    A = 32'd3;
    B = 32'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    first_done = 0;
    cap_hi = '1;
    cap_lo = '1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 10) begin
        A = 32'd100;
        B = 32'd100;
        start = 1'b1;
      end else if (k == 11) begin
        start = 1'b0;
        A = 32'd77;
        B = 32'd55;
      end
      if (done) begin
        dones++;
        if (first_done == 0) begin
          first_done = k;
          cap_hi = hi;
          cap_lo = lo;
        end
      end
    end
    chk("busy-start done count", 64'(dones), 64'd1);
    chk("busy-start latency", 64'(first_done), 64'(LAT));
    chk("busy-start product", {cap_hi, cap_lo}, {32'd0, 32'd12});
    prev_hi = 32'd0;
    prev_lo = 32'd12;

    // Asynchronous reset mid-operation discards the result.
    @(negedge clk);
    A = 32'd5;
    B = 32'd6;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async reset hi/lo", {hi, lo}, 64'd0);
    chk("async reset busy/done", {62'd0, busy, done}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("no done after reset", 64'(dones), 64'd0);
    chk("idle after reset", 64'(busy), 64'd0);
    prev_hi = '0;
    prev_lo = '0;
    run_op(32'd5, 32'd6, 32'd0, 32'd30, "after reset");

`ifdef MULT_MULTU_EN
    is_u = 1'b1;
    run_op(32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, "multu");
    is_u = 1'b0;
    run_op(32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, "mult");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_seq.md
Name: mult_seq

Overview:
Sequential signed 32x32 multiplier producing a 64-bit product split into hi/lo, for the MIPS MULT instruction. It is the inverse companion to the divider; both feed the HI/LO registers in the datapath.
- Uses a shift-add algorithm on operand magnitudes, one iteration per clock, with sign correction at the end.
- The control unit starts it with a one-cycle pulse and waits for done.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH bits, hi = upper WIDTH, lo = lower WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  one-cycle request; sampled only in IDLE
A  input  WIDTH  signed multiplicand; latched on the accepted start
B  input  WIDTH  signed multiplier; latched on the accepted start
hi  output  WIDTH  upper half of product
lo  output  WIDTH  lower half of product
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when hi/lo are updated

Behaviour:
- Reset (reset=0, any time, asynchronous): state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0, internal accumulators=0. Takes effect immediately, including mid-operation; any in-flight result is discarded.
- States: IDLE, CALC, FINISH.
- IDLE with start=1 at edge N:
  - latch |A| and |B| as WIDTH-bit unsigned magnitudes; -2^31 maps to 0x80000000, no overflow.
  - latch neg = A[31]^B[31].
  - clear the 2*WIDTH accumulator; counter=0; go to CALC; busy=1 after the edge.
- CALC, one iteration per edge:
  - if multiplier LSB=1, add the multiplicand into the upper half of the accumulator, keeping the carry (WIDTH+1-bit add).
  - shift {carry, accumulator} right by 1 and shift the multiplier right by 1; counter++.
  - after WIDTH iterations (counter reaches WIDTH-1 and iterates), go to FINISH.
- FINISH, one edge:
  - {hi,lo} = neg ? two's complement of accumulator : accumulator. A zero product stays 0.
  - done=1 for exactly this one cycle; busy=0; go to IDLE.
- Latency: start sampled at edge N; done is high, and hi/lo are valid, in the cycle after edge N+WIDTH+1 (33 edges for WIDTH=32).
- hi/lo hold their value until the next FINISH or reset. They do not change during CALC.
- start while busy (CALC/FINISH): ignored, no queuing. A and B changing during CALC do not affect the result.
- start in the same cycle done is high: the block is in IDLE after that edge, so start is accepted only if still asserted on the next edge. Control must pulse start after done.
- No overflow flag; the 64-bit product is always exact.

Optional Feature:
MULT_MULTU_EN
- Defined:
  - adds input port is_unsigned (1 bit), latched with the operands on an accepted start.
  - when latched is_unsigned=1: operands are taken as unsigned magnitudes without negation, and neg=0 (MULTU semantics).
  - latency is unchanged.
- Not defined: no is_unsigned port; all operations are signed MULT.

Test Plan:
- Reset, then start with A=7, B=-3 -> done exactly 33 edges after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy low after done.
- A=0x80000000, B=0x80000000 -> hi=0x40000000, lo=0x00000000. Then A=0x7FFFFFFF, B=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001.
- A=0, B=-5 -> hi=0, lo=0 (no -0 artifact). Then A=-1, B=-1 -> hi=0, lo=1.
- Start A=3, B=4; on cycle 10 pulse start with A=100, B=100 and change the A/B inputs -> single done; hi=0, lo=12; second start ignored.
- Start A=5, B=6; drive reset=0 at cycle 15 asynchronously, mid-cycle -> hi=0, lo=0, busy=0, done=0 immediately; release reset; no done pulse follows. New start with A=5, B=6 -> lo=30 after 33 edges.
- With MULT_MULTU_EN: A=0xFFFFFFFF, B=2, is_unsigned=1 -> hi=0x00000001, lo=0xFFFFFFFE. Same operands with is_unsigned=0 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
